router_fsm: RTL and testbench

//  Packet-sequencing controller for the 1x3 router. Decodes the 2-bit destination in the header,

---
 rtl/router_pkg.sv | 59 +++++
 rtl/router_fsm_if.sv | 34 +++
 rtl/router_fsm.sv | 96 +++++++++
 tb/tb_router_fsm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet-sequencing controller.
// The DROP_PACKET output decode exists only when ADDR_CHECK_EN is defined.
package router_pkg;

   localparam int ADDR_W    = 2;
   localparam int NUM_PORTS = 3;
   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'd0,
      LOAD_FIRST_DATA    = 4'd1,
      LOAD_DATA          = 4'd2,
      FIFO_FULL_STATE    = 4'd3,
      LOAD_AFTER_FULL    = 4'd4,
      LOAD_PARITY        = 4'd5,
      CHECK_PARITY_ERROR = 4'd6,
      WAIT_TILL_EMPTY    = 4'd7,
      DROP_PACKET        = 4'd8
   } state_t;

   typedef struct packed {
      logic detect_add;
      logic lfd_state;
      logic ld_state;
      logic laf_state;
      logic full_state;
      logic write_enb_reg;
      logic rst_int_reg;
      logic busy;
      logic drop_pkt;
   } out_t;

   // Moore decode; drop_pkt can only ever be set when the drop state is built in.
   function automatic out_t decode_outputs(state_t s);
      out_t o;
      o = '0;
      case (s)
         DECODE_ADDRESS:     o.detect_add = 1'b1;
         LOAD_FIRST_DATA:    begin o.lfd_state = 1'b1; o.busy = 1'b1; end
         LOAD_DATA:          begin o.ld_state = 1'b1; o.write_enb_reg = 1'b1; end
         FIFO_FULL_STATE:    begin o.full_state = 1'b1; o.busy = 1'b1; end
         LOAD_AFTER_FULL:    begin o.laf_state = 1'b1; o.write_enb_reg = 1'b1; o.busy = 1'b1; end
         LOAD_PARITY:        begin o.write_enb_reg = 1'b1; o.busy = 1'b1; end
         CHECK_PARITY_ERROR: begin o.rst_int_reg = 1'b1; o.busy = 1'b1; end
         WAIT_TILL_EMPTY:    o.busy = 1'b1;
`ifdef ADDR_CHECK_EN
         DROP_PACKET:        o.drop_pkt = 1'b1;
`endif
         default:            o = '0;
      endcase
      return o;
   endfunction

   // Per-port flag lookup; the invalid address selects nothing.
   function automatic logic port_sel(logic [NUM_PORTS-1:0] flags, logic [ADDR_W-1:0] addr);
      return (addr != ADDR_INVALID) && flags[addr];
   endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Source/reg/sync-facing signal bundle of the router controller.
// slave = controller side, master = environment driving the controller.
interface router_fsm_if;
   import router_pkg::*;

   logic              pkt_valid;
   logic [ADDR_W-1:0] data_in;
   logic              fifo_full;
   logic              fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic              soft_reset_0, soft_reset_1, soft_reset_2;
   logic              parity_done;
   logic              low_pkt_valid;
   logic              detect_add, lfd_state, ld_state, laf_state, full_state;
   logic              write_enb_reg, rst_int_reg, busy, drop_pkt;

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, low_pkt_valid,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
      output write_enb_reg, rst_int_reg, busy, drop_pkt
   );

   modport master (
      output pkt_valid, data_in, fifo_full,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, low_pkt_valid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
      input  write_enb_reg, rst_int_reg, busy, drop_pkt
   );

endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router (Moore FSM, registered outputs).
// Define ADDR_CHECK_EN to drop packets addressed to the invalid port 2'b11.
//
// state              | meaning
// DECODE_ADDRESS     | idle, header address strobe
// LOAD_FIRST_DATA    | header byte load
// LOAD_DATA          | payload streaming into FIFO
// FIFO_FULL_STATE    | stalled on full FIFO
// LOAD_AFTER_FULL    | resume write of the held byte
// LOAD_PARITY        | parity byte write
// CHECK_PARITY_ERROR | clear router_reg flags
// WAIT_TILL_EMPTY    | destination FIFO still draining
// DROP_PACKET        | discarding invalid-address packet
module router_fsm
   import router_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   router_fsm_if.slave    bus
);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q;
   out_t                  out_q;
   logic [NUM_PORTS-1:0]  empty_v, srst_v;
   logic                  empty_hdr, empty_q, srst_q;

   assign empty_v   = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
   assign srst_v    = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
   assign empty_hdr = port_sel(empty_v, bus.data_in);
   assign empty_q   = port_sel(empty_v, addr_q);
   assign srst_q    = port_sel(srst_v, addr_q);

   always_comb begin
      state_d = state_q;
      if (srst_q && (state_q != DECODE_ADDRESS)) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               if (bus.pkt_valid) begin
                  if (bus.data_in != ADDR_INVALID)
                     state_d = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ADDR_CHECK_EN
                  else
                     state_d = DROP_PACKET;
`endif
               end
            end
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA: begin
               if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
               else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE:    if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
               if (bus.parity_done)        state_d = DECODE_ADDRESS;
               else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
               else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:    if (empty_q) state_d = LOAD_FIRST_DATA;
`ifdef ADDR_CHECK_EN
            DROP_PACKET:        state_d = bus.pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
`endif
            default:            state_d = DECODE_ADDRESS;
         endcase
      end
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= '0;
         out_q   <= decode_outputs(DECODE_ADDRESS);
      end else begin
         state_q <= state_d;
         out_q   <= decode_outputs(state_d);
         if ((state_q == DECODE_ADDRESS) && bus.pkt_valid)
            addr_q <= bus.data_in;
      end
   end

   assign bus.detect_add    = out_q.detect_add;
   assign bus.lfd_state     = out_q.lfd_state;
   assign bus.ld_state      = out_q.ld_state;
   assign bus.laf_state     = out_q.laf_state;
   assign bus.full_state    = out_q.full_state;
   assign bus.write_enb_reg = out_q.write_enb_reg;
   assign bus.rst_int_reg   = out_q.rst_int_reg;
   assign bus.busy          = out_q.busy;
   assign bus.drop_pkt      = out_q.drop_pkt;

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed vector table, a streaming sequence, then
// random stimulus against a behavioural model of the packet protocol.
module tb_router_fsm;
   import router_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   router_fsm_if bus();
   router_fsm dut (.clock(clk), .reset(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   // {detect_add,lfd,ld,laf,full,write_enb,rst_int,busy,drop}
   localparam logic [8:0] O_DEC  = 9'h100;
   localparam logic [8:0] O_LFD  = 9'h082;
   localparam logic [8:0] O_LD   = 9'h048;
   localparam logic [8:0] O_LAF  = 9'h02A;
   localparam logic [8:0] O_FULL = 9'h012;
   localparam logic [8:0] O_LP   = 9'h00A;
   localparam logic [8:0] O_CPE  = 9'h006;
   localparam logic [8:0] O_WAIT = 9'h002;
   localparam logic [8:0] O_DROP = 9'h001;
`ifdef ADDR_CHECK_EN
   localparam logic [8:0] O_BAD  = O_DROP;
`else
   localparam logic [8:0] O_BAD  = O_DEC;
`endif

   typedef struct {
      string       name;
      logic        r, pv;
      logic [1:0]  din;
      logic        full;
      logic [2:0]  empty, srst;
      logic        pdone, lpv;
      logic [8:0]  exp;
   } vec_t;
   vec_t vecs[$];

   string      m_st   = "DEC";
   logic [1:0] m_addr = 2'b00;

   task automatic add(input string n, input logic r, input logic pv, input logic [1:0] d,
                      input logic f, input logic [2:0] e, input logic [2:0] s,
                      input logic pd, input logic lp, input logic [8:0] x);
      vec_t v;
      v.name = n; v.r = r; v.pv = pv; v.din = d; v.full = f; v.empty = e;
      v.srst = s; v.pdone = pd; v.lpv = lp; v.exp = x;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic pv, input logic [1:0] d, input logic f,
                        input logic [2:0] e, input logic [2:0] s, input logic pd, input logic lp);
      rst = r;
      bus.pkt_valid = pv;
      bus.data_in = d;
      bus.fifo_full = f;
      {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0} = e;
      {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} = s;
      bus.parity_done = pd;
      bus.low_pkt_valid = lp;
   endtask

   function automatic logic [8:0] dut_out();
      return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
              bus.write_enb_reg, bus.rst_int_reg, bus.busy, bus.drop_pkt};
   endfunction

   // Protocol-level reference: which phase of a packet the router is in next.
   function automatic string m_next();
      logic [2:0] e, s;
      e = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
      s = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
      if (rst) return "DEC";
      if (m_st != "DEC" && m_addr != 2'b11 && s[m_addr]) return "DEC";
      if (m_st == "DEC") begin
         if (!bus.pkt_valid) return "DEC";
         if (bus.data_in == 2'b11) begin
`ifdef ADDR_CHECK_EN
            return "DROP";
`else
            return "DEC";
`endif
         end
         return e[bus.data_in] ? "LFD" : "WAIT";
      end
      if (m_st == "LFD")  return "LD";
      if (m_st == "LD")   return bus.fifo_full ? "FULL" : (bus.pkt_valid ? "LD" : "LP");
      if (m_st == "FULL") return bus.fifo_full ? "FULL" : "LAF";
      if (m_st == "LAF")  return bus.parity_done ? "DEC" : (bus.low_pkt_valid ? "LP" : "LD");
      if (m_st == "LP")   return "CPE";
      if (m_st == "CPE")  return bus.fifo_full ? "FULL" : "DEC";
      if (m_st == "WAIT") return e[m_addr] ? "LFD" : "WAIT";
      if (m_st == "DROP") return bus.pkt_valid ? "DROP" : "DEC";
      return "DEC";
   endfunction

   function automatic logic [8:0] m_out(input string s);
      if (s == "LFD")  return O_LFD;
      if (s == "LD")   return O_LD;
      if (s == "FULL") return O_FULL;
      if (s == "LAF")  return O_LAF;
      if (s == "LP")   return O_LP;
      if (s == "CPE")  return O_CPE;
      if (s == "WAIT") return O_WAIT;
      if (s == "DROP") return O_DROP;
      return O_DEC;
   endfunction

   task automatic tick();
      string      n;
      logic [1:0] na;
      n = m_next();
      if (rst) na = 2'b00;
      else if (m_st == "DEC" && bus.pkt_valid) na = bus.data_in;
      else na = m_addr;
      @(posedge clk);
      #1;
      m_st = n;
      m_addr = na;
   endtask

   task automatic check(input string n, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
      end
   endtask

   initial begin
      //  name          rst pv din  full empty   srst    pd lp expected
      add("reset_a",     1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_DEC);
      add("reset_b",     1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_DEC);
      add("p1_hdr",      0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LFD);
      add("p1_ld1",      0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LD);
      add("p1_ld2",      0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LD);
      add("p1_ld3",      0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LD);
      add("p1_lp",       0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LP);
      add("p1_cpe",      0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_CPE);
      add("p1_dec",      0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_DEC);
      add("wait_0",      0, 1, 2'd2, 0, 3'b000, 3'b000, 0, 0, O_WAIT);
      add("wait_1",      0, 1, 2'd2, 0, 3'b000, 3'b000, 0, 0, O_WAIT);
      add("wait_2",      0, 1, 2'd2, 0, 3'b000, 3'b000, 0, 0, O_WAIT);
      add("wait_3",      0, 1, 2'd2, 0, 3'b000, 3'b000, 0, 0, O_WAIT);
      add("wait_4",      0, 1, 2'd2, 0, 3'b000, 3'b000, 0, 0, O_WAIT);
      add("wait_lfd",    0, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, O_LFD);
      add("wait_ld",     0, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, O_LD);
      add("full_1",      0, 1, 2'd2, 1, 3'b100, 3'b000, 0, 0, O_FULL);
      add("full_2",      0, 1, 2'd2, 1, 3'b100, 3'b000, 0, 0, O_FULL);
      add("full_3",      0, 1, 2'd2, 1, 3'b100, 3'b000, 0, 0, O_FULL);
      add("full_4",      0, 1, 2'd2, 1, 3'b100, 3'b000, 0, 0, O_FULL);
      add("full_laf",    0, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, O_LAF);
      add("laf_ld",      0, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, O_LD);
      add("full_lp",     0, 0, 2'd2, 0, 3'b100, 3'b000, 0, 0, O_LP);
      add("full_cpe",    0, 0, 2'd2, 0, 3'b100, 3'b000, 0, 0, O_CPE);
      add("full_dec",    0, 0, 2'd2, 0, 3'b100, 3'b000, 0, 0, O_DEC);
      add("sr_hdr",      0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LFD);
      add("sr_ld",       0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LD);
      add("sr_other",    0, 1, 2'd0, 0, 3'b001, 3'b010, 0, 0, O_LD);
      add("sr_own",      0, 1, 2'd0, 0, 3'b001, 3'b001, 0, 0, O_DEC);
      add("bad_1",       0, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_BAD);
      add("bad_2",       0, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_BAD);
      add("bad_3",       0, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_BAD);
      add("bad_end",     0, 0, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_DEC);
      add("prio_hdr",    0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LFD);
      add("prio_ld",     0, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LD);
      add("prio_full",   0, 0, 2'd0, 1, 3'b001, 3'b000, 0, 0, O_FULL);
      add("prio_laf",    0, 0, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LAF);
      add("laf_lowpv",   0, 0, 2'd0, 0, 3'b001, 3'b000, 0, 1, O_LP);
      add("lp_cpe",      0, 0, 2'd0, 1, 3'b001, 3'b000, 0, 0, O_CPE);
      add("cpe_full",    0, 0, 2'd0, 1, 3'b001, 3'b000, 0, 0, O_FULL);
      add("cpe_laf",     0, 0, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LAF);
      add("laf_pdone",   0, 0, 2'd0, 0, 3'b001, 3'b000, 1, 0, O_DEC);
      add("mid_hdr",     0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LFD);
      add("mid_ld",      0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LD);
      add("mid_reset",   1, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_DEC);
      add("srw_wait",    0, 1, 2'd2, 0, 3'b000, 3'b000, 0, 0, O_WAIT);
      add("srw_dec",     0, 0, 2'd2, 0, 3'b000, 3'b100, 0, 0, O_DEC);
      add("sr_in_dec",   0, 0, 2'd0, 0, 3'b111, 3'b111, 0, 0, O_DEC);

      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].pv, vecs[i].din, vecs[i].full, vecs[i].empty,
               vecs[i].srst, vecs[i].pdone, vecs[i].lpv);
         tick();
         check(vecs[i].name, dut_out(), vecs[i].exp);
      end

      // Long payload: source must never see busy while bytes stream.
      drive(0, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0);
      tick();
      check("stream_hdr", dut_out(), O_LFD);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("stream_ld", dut_out(), O_LD);
         check("stream_busy", {8'd0, bus.busy}, 9'd0);
      end
      drive(0, 0, 2'd1, 0, 3'b010, 3'b000, 0, 0);
      tick();
      check("stream_lp", dut_out(), O_LP);
      tick();
      check("stream_cpe", dut_out(), O_CPE);
      tick();
      check("stream_dec", dut_out(), O_DEC);

      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(63) == 0, $urandom_range(3) != 0, 2'($urandom_range(3)),
               $urandom_range(3) == 0, 3'($urandom_range(7)),
               {$urandom_range(15) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0},
               $urandom_range(3) == 0, $urandom_range(3) == 0);
         tick();
         check("random", dut_out(), m_out(m_st));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
